// File: rtl/layer_bus_defs_pkg.sv
// Shared layer/bus-adapter definitions: default element geometry and packer state encodings.
package layer_bus_defs_pkg;

  localparam int ELEM_W_DFLT    = 16;
  localparam int NUM_ELEMS_DFLT = 256;

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } pk_state_e;

endpackage

// File: rtl/layer_input_packer.sv
// Collects a frame of signed samples into the layer's flat input bus, launches the layer,
// and freezes the bus until the layer reports completion.
module layer_input_packer
  import layer_bus_defs_pkg::*;
#(
  parameter int ELEM_W    = ELEM_W_DFLT,
  parameter int NUM_ELEMS = NUM_ELEMS_DFLT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_valid,
  input  logic signed [ELEM_W-1:0]            s_data,
  input  logic                                s_last,
  output logic                                s_ready,
  output logic signed [ELEM_W*NUM_ELEMS-1:0]  flat_out,
  output logic                                layer_start,
  input  logic                                layer_done,
  output logic                                busy,
  output logic                                frame_err
);

  localparam int FLAT_W = ELEM_W * NUM_ELEMS;
  localparam int IDX_W  = $clog2(NUM_ELEMS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  pk_state_e                 state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [FLAT_W-1:0]  flat_q, flat_d;
  logic                      start_q, start_d;
  logic                      err_q, err_d;
  logic                      accept;

  // s_ready is decoded straight from state so the layer bus can never be written outside FILL.
  assign s_ready     = (state_q == ST_FILL) && !rst;
  assign accept      = s_valid && s_ready;
  assign busy        = (state_q != ST_FILL);
  assign flat_out    = flat_q;
  assign layer_start = start_q;
  assign frame_err   = err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    flat_d  = flat_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          for (int i = 0; i < NUM_ELEMS; i++) begin
            if (idx_q == IDX_W'(i)) flat_d[i*ELEM_W +: ELEM_W] = s_data;
          end
          // A full frame always launches; a missing s_last is only flagged.
          if (idx_q == LAST_IDX) begin
            state_d = ST_LAUNCH;
            idx_d   = '0;
            start_d = 1'b1;
            err_d   = !s_last;
          end else if (s_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (layer_done) begin
          state_d = ST_FILL;
          idx_d   = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      flat_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      flat_q  <= flat_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_layer_input_packer.sv
// Directed bench for layer_input_packer: table of frame scenarios plus stall and reset sequences.
module tb_layer_input_packer;

  localparam int EW = 16;
  localparam int NE = 256;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       s_valid;
  logic signed [EW-1:0]       s_data;
  logic                       s_last;
  logic                       s_ready;
  logic signed [EW*NE-1:0]    flat_out;
  logic                       layer_start;
  logic                       layer_done;
  logic                       busy;
  logic                       frame_err;

  layer_input_packer #(.ELEM_W(EW), .NUM_ELEMS(NE)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .flat_out(flat_out), .layer_start(layer_start),
    .layer_done(layer_done), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    len;
    int    last_at;
    int    base;
    int    step;
    int    done_at;
    bit    exp_err;
    bit    exp_start;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int acc_cnt = 0;
  int start_cyc = -1;
  int last_acc_cyc = -1;
  logic signed [EW*NE-1:0] exp_flat = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (layer_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (s_valid && s_ready) begin
      acc_cnt++;
      last_acc_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("ready_timeout", longint'(s_ready), 1);
  endtask

  task automatic send_frame(input int len, input int last_at, input int base, input int step,
                            input int done_at);
    logic signed [EW-1:0] d;
    for (int s = 0; s < len; s++) begin
      d          = EW'(base + s * step);
      s_valid    = 1'b1;
      s_data     = d;
      s_last     = (s == last_at);
      layer_done = (s == done_at);
      wait_ready();
      exp_flat[s*EW +: EW] = d;
      tick();
      layer_done = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int sc, ec, ac;
    bit rdy_bad;
    sc = start_cnt;
    ec = err_cnt;
    ac = acc_cnt;
    rdy_bad = 1'b0;
    send_frame(v.len, v.last_at, v.base, v.step, v.done_at);
    repeat (4) begin
      if (s_ready) rdy_bad = 1'b1;
      tick();
    end
    chk({v.name, "_accepted"}, longint'(acc_cnt - ac), longint'(v.len));
    chk({v.name, "_start_pulses"}, longint'(start_cnt - sc), longint'(v.exp_start));
    chk({v.name, "_err_pulses"}, longint'(err_cnt - ec), longint'(v.exp_err));
    chk({v.name, "_flat"}, longint'(flat_out == exp_flat), 1);
    if (v.exp_start) begin
      chk({v.name, "_start_latency"}, longint'(start_cyc - last_acc_cyc), 1);
      chk({v.name, "_ready_low_wait"}, longint'(rdy_bad), 0);
      chk({v.name, "_busy_wait"}, longint'(busy), 1);
      layer_done = 1'b1;
      tick();
      layer_done = 1'b0;
      chk({v.name, "_ready_after_done"}, longint'(s_ready), 1);
      chk({v.name, "_busy_after_done"}, longint'(busy), 0);
    end else begin
      chk({v.name, "_ready_fill"}, longint'(s_ready), 1);
      chk({v.name, "_busy_fill"}, longint'(busy), 0);
    end
  endtask

  vec_t vecs[5];

  initial begin
    logic signed [EW*NE-1:0] snap;
    bit stable;
    int sc, ac;

    vecs[0] = '{"normal",        256, 255,      0,  1, -1, 1'b0, 1'b1};
    vecs[1] = '{"short",         100,  99,   1000,  3, -1, 1'b1, 1'b0};
    vecs[2] = '{"after_short",   256, 255,   -128,  7, -1, 1'b0, 1'b1};
    vecs[3] = '{"no_last",       256,  -1,  23130, -1, -1, 1'b1, 1'b1};
    vecs[4] = '{"spurious_done", 256, 255, -32768,  1, 10, 1'b0, 1'b1};

    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    layer_done = 1'b0;
    repeat (3) tick();
    chk("rst_ready", longint'(s_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_start", longint'(layer_start), 0);
    chk("rst_err", longint'(frame_err), 0);
    chk("rst_flat_zero", longint'(flat_out == '0), 1);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", longint'(s_ready), 1);
    chk("post_rst_no_start", longint'(start_cnt), 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Stall: layer holds the bus for 300 cycles while upstream keeps offering data.
    send_frame(256, 255, 32767, 0, -1);
    snap    = flat_out;
    stable  = 1'b1;
    ac      = acc_cnt;
    s_valid = 1'b1;
    s_data  = 16'sh1234;
    s_last  = 1'b0;
    repeat (299) begin
      if (flat_out != snap || s_ready) stable = 1'b0;
      tick();
    end
    layer_done = 1'b1;
    if (flat_out != snap || s_ready) stable = 1'b0;
    tick();
    layer_done = 1'b0;
    chk("stall_flat_stable", longint'(stable), 1);
    chk("stall_flat_value", longint'(flat_out == exp_flat), 1);
    chk("stall_no_accept", longint'(acc_cnt - ac), 0);
    chk("stall_ready_after_done", longint'(s_ready), 1);
    tick();
    s_valid = 1'b0;
    chk("stall_first_accept", longint'(flat_out[0 +: EW]), 16'sh1234);

    // Reset mid-frame, then again while waiting on the layer.
    sc = start_cnt;
    send_frame(128, -1, 5, 1, -1);
    rst = 1'b1;
    #1;
    chk("rst_mid_flat", longint'(flat_out == '0), 1);
    chk("rst_mid_ready", longint'(s_ready), 0);
    chk("rst_mid_busy", longint'(busy), 0);
    chk("rst_mid_start", longint'(layer_start), 0);
    chk("rst_mid_err", longint'(frame_err), 0);
    tick();
    rst = 1'b0;
    exp_flat = '0;
    chk("rst_mid_no_launch", longint'(start_cnt - sc), 0);

    send_frame(256, 255, 9, 2, -1);
    repeat (3) tick();
    chk("pre_rst_wait_busy", longint'(busy), 1);
    sc = start_cnt;
    rst = 1'b1;
    #1;
    chk("rst_wait_busy", longint'(busy), 0);
    chk("rst_wait_flat", longint'(flat_out == '0), 1);
    chk("rst_wait_start", longint'(layer_start), 0);
    repeat (2) tick();
    rst = 1'b0;
    exp_flat = '0;
    repeat (5) tick();
    chk("rst_wait_no_launch", longint'(start_cnt - sc), 0);
    chk("rst_wait_ready", longint'(s_ready), 1);

    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
